// File: rtl/asrv32_writeback_unit.sv
// asrv32 writeback/commit stage: selects the rd value, owns and advances the
// architectural PC, waits for multi-cycle loads and traps on misaligned targets.
// Optional feature macro: ASRV32_WB_INSTRET_EN enables the 64-bit retired
// instruction counter on o_instret; otherwise o_instret is tied to zero.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef RTYPE
`define RTYPE 0
`endif
`ifndef ITYPE
`define ITYPE 1
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef STORE
`define STORE 3
`endif
`ifndef BRANCH
`define BRANCH 4
`endif
`ifndef JAL
`define JAL 5
`endif
`ifndef JALR
`define JALR 6
`endif
`ifndef LUI
`define LUI 7
`endif
`ifndef AUIPC
`define AUIPC 8
`endif
`ifndef SYSTEM
`define SYSTEM 9
`endif
`ifndef FENCE
`define FENCE 10
`endif

module asrv32_writeback_unit #(
    parameter int                XLEN        = 32,
    parameter logic [XLEN-1:0]   PC_RESET    = '0,
    parameter logic [31:0]       TRAP_VECTOR = 32'h0000_0004,
    parameter int                IALIGN      = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [`OPCODE_WIDTH-1:0] i_opcode,
    input  logic [4:0]               i_rd_addr,
    input  logic [XLEN-1:0]          i_result_from_alu,
    input  logic [XLEN-1:0]          i_imm,
    input  logic [XLEN-1:0]          i_rs1_data,
    input  logic [XLEN-1:0]          i_load_data_from_memory,
    input  logic                     i_load_done,
    input  logic                     i_flush,
    output logic [XLEN-1:0]          o_rd,
    output logic [4:0]               o_rd_addr,
    output logic                     o_wr_rd_en,
    output logic [XLEN-1:0]          o_pc,
    output logic                     o_pc_update,
    output logic                     o_trap,
    output logic [63:0]              o_instret
);

    localparam logic [XLEN-1:0] TRAP_PC = XLEN'(TRAP_VECTOR);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD_WAIT, ST_COMMIT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] cap_pc_q, cap_pc_d;
    logic [XLEN-1:0] cap_rd_q, cap_rd_d;
    logic [4:0]      cap_rd_addr_q, cap_rd_addr_d;
    logic            cap_wr_q, cap_wr_d;
    logic            cap_trap_q, cap_trap_d;
    logic [XLEN-1:0] o_pc_q, o_pc_d;
    logic [XLEN-1:0] o_rd_q, o_rd_d;
    logic [4:0]      o_rd_addr_q, o_rd_addr_d;
    logic            o_wr_rd_en_q, o_wr_rd_en_d;
    logic            o_pc_update_q, o_pc_update_d;
    logic            o_trap_q, o_trap_d;

    logic            is_load, is_branch, is_jal, is_jalr, taken, misaligned, writes_rd;
    logic [XLEN-1:0] sum, target, pc_plus4, next_pc, rd_sel;

    // Decode the incoming instruction: shared adder, next PC, rd value and trap.
    always_comb begin
        is_load   = i_opcode[`LOAD];
        is_branch = i_opcode[`BRANCH];
        is_jal    = i_opcode[`JAL];
        is_jalr   = i_opcode[`JALR];
        pc_plus4  = o_pc_q + XLEN'(4);
        sum       = (is_jalr ? i_rs1_data : o_pc_q) + i_imm;
        target    = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
        taken     = is_jal | is_jalr | (is_branch & i_result_from_alu[0]);
        misaligned = (IALIGN == 16) ? target[0] : (target[1:0] != 2'b00);
        if (!taken)          next_pc = pc_plus4;
        else if (misaligned) next_pc = TRAP_PC;
        else                 next_pc = target;
        rd_sel = '0;
        if (i_opcode[`RTYPE] | i_opcode[`ITYPE]) rd_sel = i_result_from_alu;
        else if (is_jal | is_jalr)               rd_sel = pc_plus4;
        else if (i_opcode[`LUI])                 rd_sel = i_imm;
        else if (i_opcode[`AUIPC])               rd_sel = sum;
        // Only opcodes that produce a result may write; zero/unknown opcodes never do.
        writes_rd = (i_opcode[`RTYPE] | i_opcode[`ITYPE] | is_load | is_jal | is_jalr |
                     i_opcode[`LUI] | i_opcode[`AUIPC]) &
                    ~(is_branch | i_opcode[`STORE] | i_opcode[`SYSTEM] | i_opcode[`FENCE]) &
                    (i_rd_addr != 5'd0) & ~(taken & misaligned);
    end

    // Next-state logic: capture on accept, wait for load data, then commit for one cycle.
    always_comb begin
        state_d       = state_q;
        cap_pc_d      = cap_pc_q;
        cap_rd_d      = cap_rd_q;
        cap_rd_addr_d = cap_rd_addr_q;
        cap_wr_d      = cap_wr_q;
        cap_trap_d    = cap_trap_q;
        o_pc_d        = o_pc_q;
        o_rd_d        = o_rd_q;
        o_rd_addr_d   = o_rd_addr_q;
        o_wr_rd_en_d  = 1'b0;
        o_pc_update_d = 1'b0;
        o_trap_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    cap_pc_d      = next_pc;
                    cap_rd_d      = rd_sel;
                    cap_rd_addr_d = i_rd_addr;
                    cap_wr_d      = writes_rd;
                    cap_trap_d    = taken & misaligned;
                    state_d       = is_load ? ST_LOAD_WAIT : ST_COMMIT;
                end
            end
            ST_LOAD_WAIT: begin
                // A flush kills the load even when the data arrives in the same cycle.
                if (i_flush) begin
                    state_d = ST_IDLE;
                end else if (i_load_done) begin
                    cap_rd_d = i_load_data_from_memory;
                    state_d  = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                o_pc_d        = cap_pc_q;
                o_rd_d        = cap_rd_q;
                o_rd_addr_d   = cap_rd_addr_q;
                o_wr_rd_en_d  = cap_wr_q;
                o_pc_update_d = 1'b1;
                o_trap_d      = cap_trap_q;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            cap_pc_q      <= '0;
            cap_rd_q      <= '0;
            cap_rd_addr_q <= '0;
            cap_wr_q      <= 1'b0;
            cap_trap_q    <= 1'b0;
            o_pc_q        <= PC_RESET;
            o_rd_q        <= '0;
            o_rd_addr_q   <= '0;
            o_wr_rd_en_q  <= 1'b0;
            o_pc_update_q <= 1'b0;
            o_trap_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cap_pc_q      <= cap_pc_d;
            cap_rd_q      <= cap_rd_d;
            cap_rd_addr_q <= cap_rd_addr_d;
            cap_wr_q      <= cap_wr_d;
            cap_trap_q    <= cap_trap_d;
            o_pc_q        <= o_pc_d;
            o_rd_q        <= o_rd_d;
            o_rd_addr_q   <= o_rd_addr_d;
            o_wr_rd_en_q  <= o_wr_rd_en_d;
            o_pc_update_q <= o_pc_update_d;
            o_trap_q      <= o_trap_d;
        end
    end

`ifdef ASRV32_WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    // Count every commit that did not trap; wraps naturally at 2^64.
    always_comb begin
        instret_d = instret_q;
        if (state_q == ST_COMMIT && !cap_trap_q) instret_d = instret_q + 64'd1;
    end

    // Retired-instruction counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) instret_q <= '0;
        else          instret_q <= instret_d;
    end

    assign o_instret = instret_q;
`else
    assign o_instret = '0;
`endif

    assign o_ready     = (state_q == ST_IDLE);
    assign o_rd        = o_rd_q;
    assign o_rd_addr   = o_rd_addr_q;
    assign o_wr_rd_en  = o_wr_rd_en_q;
    assign o_pc        = o_pc_q;
    assign o_pc_update = o_pc_update_q;
    assign o_trap      = o_trap_q;

endmodule

// File: tb/tb_asrv32_writeback_unit.sv
// Randomized bench for asrv32_writeback_unit with a transaction-level model of
// the PC / rd / trap / retire rules and a per-cycle output compare.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef RTYPE
`define RTYPE 0
`endif
`ifndef ITYPE
`define ITYPE 1
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef STORE
`define STORE 3
`endif
`ifndef BRANCH
`define BRANCH 4
`endif
`ifndef JAL
`define JAL 5
`endif
`ifndef JALR
`define JALR 6
`endif
`ifndef LUI
`define LUI 7
`endif
`ifndef AUIPC
`define AUIPC 8
`endif
`ifndef SYSTEM
`define SYSTEM 9
`endif
`ifndef FENCE
`define FENCE 10
`endif

module tb_asrv32_writeback_unit;

    logic                     i_clk = 1'b0;
    logic                     i_rst_n = 1'b0;
    logic                     i_valid = 1'b0;
    logic                     o_ready;
    logic [`OPCODE_WIDTH-1:0] i_opcode = '0;
    logic [4:0]               i_rd_addr = '0;
    logic [31:0]              i_result_from_alu = '0;
    logic [31:0]              i_imm = '0;
    logic [31:0]              i_rs1_data = '0;
    logic [31:0]              i_load_data_from_memory = '0;
    logic                     i_load_done = 1'b0;
    logic                     i_flush = 1'b0;
    logic [31:0]              o_rd;
    logic [4:0]               o_rd_addr;
    logic                     o_wr_rd_en;
    logic [31:0]              o_pc;
    logic                     o_pc_update;
    logic                     o_trap;
    logic [63:0]              o_instret;

    asrv32_writeback_unit #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_opcode(i_opcode), .i_rd_addr(i_rd_addr), .i_result_from_alu(i_result_from_alu),
        .i_imm(i_imm), .i_rs1_data(i_rs1_data), .i_load_data_from_memory(i_load_data_from_memory),
        .i_load_done(i_load_done), .i_flush(i_flush), .o_rd(o_rd), .o_rd_addr(o_rd_addr),
        .o_wr_rd_en(o_wr_rd_en), .o_pc(o_pc), .o_pc_update(o_pc_update), .o_trap(o_trap),
        .o_instret(o_instret)
    );

    always #5 i_clk = ~i_clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          cmp_en = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic [63:0] m_instret = 64'h0;
    logic        exp_ready = 1'b1, exp_wr = 1'b0, exp_upd = 1'b0, exp_trap = 1'b0;
    logic [31:0] exp_rd = 32'h0;
    logic [4:0]  exp_rd_addr = 5'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model's expected outputs.
    always @(negedge i_clk) begin
        if (cmp_en && i_rst_n) begin
            chk("ready", o_ready, exp_ready);
            chk("wr_rd_en", o_wr_rd_en, exp_wr);
            chk("pc_update", o_pc_update, exp_upd);
            chk("trap", o_trap, exp_trap);
            chk("pc", o_pc, m_pc);
            chk("instret", o_instret, m_instret);
            if (exp_wr) begin
                chk("rd", o_rd, exp_rd);
                chk("rd_addr", o_rd_addr, exp_rd_addr);
            end
        end
    end

    function automatic logic [`OPCODE_WIDTH-1:0] onehot(input int idx);
        onehot = '0;
        if (idx < `OPCODE_WIDTH) onehot[idx] = 1'b1;
    endfunction

    // Architectural effect of one instruction at PC m_pc.
    function automatic void model(input int op, input logic [31:0] alu, imm, rs1, ld,
                                  input logic [4:0] rd, output logic [31:0] nxt,
                                  output logic [31:0] rdv, output bit wr, output bit trap);
        bit          taken = 0;
        bit          produces = 0;
        logic [31:0] tgt = 32'h0;
        rdv = 32'h0;
        case (op)
            `RTYPE, `ITYPE: begin rdv = alu; produces = 1; end
            `LOAD:          begin rdv = ld; produces = 1; end
            `LUI:           begin rdv = imm; produces = 1; end
            `AUIPC:         begin rdv = m_pc + imm; produces = 1; end
            `JAL:           begin taken = 1; tgt = m_pc + imm; rdv = m_pc + 4; produces = 1; end
            `JALR:          begin taken = 1; tgt = (rs1 + imm) & ~32'h1; rdv = m_pc + 4; produces = 1; end
            `BRANCH:        begin taken = alu[0]; tgt = m_pc + imm; end
            default:        ;
        endcase
        trap = taken && (tgt % 4 != 0);
        nxt  = trap ? 32'h4 : (taken ? tgt : m_pc + 4);
        wr   = produces && rd != 0 && !trap;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
        exp_wr = 1'b0;
        exp_upd = 1'b0;
        exp_trap = 1'b0;
    endtask

    task automatic garbage(input bit flush_ok, input bit done_ok);
        i_valid = 1'($urandom);
        i_opcode = onehot($urandom_range(0, 11));
        i_result_from_alu = $urandom;
        i_imm = $urandom;
        i_rs1_data = $urandom;
        i_rd_addr = 5'($urandom);
        i_load_data_from_memory = $urandom;
        i_flush = flush_ok ? 1'($urandom) : 1'b0;
        i_load_done = done_ok ? 1'($urandom) : 1'b0;
    endtask

    task automatic idle_inputs();
        garbage(0, 0);
        i_valid = 1'b0;
    endtask

    // mode: 0 load completes, 1 flush with load_done, 2 flush alone.
    task automatic txn(input int op, input logic [31:0] alu, imm, rs1, input logic [4:0] rd,
                       input int mode, input int dly, input logic [31:0] ld);
        logic [31:0] nxt, rdv;
        bit          wr, trap;
        model(op, alu, imm, rs1, ld, rd, nxt, rdv, wr, trap);
        i_valid = 1'b1; i_opcode = onehot(op); i_result_from_alu = alu; i_imm = imm;
        i_rs1_data = rs1; i_rd_addr = rd; i_flush = 1'b0; i_load_done = 1'b0;
        i_load_data_from_memory = $urandom;
        tick();
        exp_ready = 1'b0;
        if (op == `LOAD) begin
            repeat (dly) begin garbage(0, 0); tick(); end
            garbage(0, 0);
            i_load_done = (mode != 2);
            i_load_data_from_memory = ld;
            i_flush = (mode != 0);
            tick();
            if (mode != 0) begin
                exp_ready = 1'b1;
                idle_inputs();
                $display("txn op=%0d rd=%0d flushed pc=0x%08h", op, rd, m_pc);
                return;
            end
        end
        garbage(1, 1);
        tick();
        m_pc = nxt; exp_upd = 1'b1; exp_trap = trap; exp_wr = wr; exp_ready = 1'b1;
        if (wr) begin exp_rd = rdv; exp_rd_addr = rd; end
`ifdef ASRV32_WB_INSTRET_EN
        if (!trap) m_instret = m_instret + 1;
`endif
        idle_inputs();
        $display("txn op=%0d rd=%0d wr=%0d rdv=0x%08h pc=0x%08h trap=%0d", op, rd, wr, rdv, m_pc, trap);
    endtask

    initial begin
        logic [63:0] saved;
        int          op;
        logic [31:0] imm, rs1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_pc", o_pc, 32'h0);
        chk("reset_ready", o_ready, 1'b1);
        chk("reset_wr", o_wr_rd_en, 1'b0);
        chk("reset_upd", o_pc_update, 1'b0);
        chk("reset_trap", o_trap, 1'b0);
        chk("reset_rd", o_rd, 32'h0);
        chk("reset_instret", o_instret, 64'h0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        cmp_en = 1'b1;

        txn(`ITYPE, 32'h15, 32'h0, 32'h0, 5'd5, 0, 0, 32'h0);
        chk("lit_itype_rd", o_rd, 32'h15);
        chk("lit_itype_addr", o_rd_addr, 5'd5);
        chk("lit_itype_wr", o_wr_rd_en, 1'b1);
        chk("lit_itype_pc", o_pc, 32'h4);
        chk("lit_itype_upd", o_pc_update, 1'b1);
        txn(`JAL, 32'h0, 32'hFC, 32'h0, 5'd0, 0, 0, 32'h0);
        chk("lit_jal_pc", o_pc, 32'h100);
        txn(`BRANCH, 32'h1, 32'h20, 32'h0, 5'd4, 0, 0, 32'h0);
        chk("lit_br_taken_pc", o_pc, 32'h120);
        chk("lit_br_taken_wr", o_wr_rd_en, 1'b0);
        txn(`BRANCH, 32'h0, 32'h20, 32'h0, 5'd4, 0, 0, 32'h0);
        chk("lit_br_nt_pc", o_pc, 32'h124);
        txn(`JAL, 32'h0, 32'hDC, 32'h0, 5'd0, 0, 0, 32'h0);
        chk("lit_jal2_pc", o_pc, 32'h200);
        txn(`JALR, 32'h0, 32'h0, 32'h301, 5'd1, 0, 0, 32'h0);
        chk("lit_jalr_pc", o_pc, 32'h300);
        chk("lit_jalr_rd", o_rd, 32'h204);
        txn(`LOAD, 32'h0, 32'h0, 32'h0, 5'd3, 0, 3, 32'hDEAD_BEEF);
        chk("lit_load_rd", o_rd, 32'hDEAD_BEEF);
        chk("lit_load_wr", o_wr_rd_en, 1'b1);
        chk("lit_load_pc", o_pc, 32'h304);
        txn(`LOAD, 32'h0, 32'h0, 32'h0, 5'd3, 1, 1, 32'h1234_5678);
        chk("lit_flush_pc", o_pc, 32'h304);
        chk("lit_flush_ready", o_ready, 1'b1);
        chk("lit_flush_wr", o_wr_rd_en, 1'b0);
        txn(`JALR, 32'h0, 32'h0, 32'h100, 5'd0, 0, 0, 32'h0);
        saved = o_instret;
        txn(`JAL, 32'h0, 32'h6, 32'h0, 5'd7, 0, 0, 32'h0);
        chk("lit_trap", o_trap, 1'b1);
        chk("lit_trap_pc", o_pc, 32'h4);
        chk("lit_trap_wr", o_wr_rd_en, 1'b0);
        chk("lit_trap_instret", o_instret, saved);

        for (int n = 0; n < 300; n++) begin
            op  = $urandom_range(0, 11);
            imm = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & ~32'h3);
            rs1 = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & ~32'h3);
            txn(op, $urandom, imm, rs1, 5'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                $urandom_range(0, 4), $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Asynchronous reset in the middle of a load wait.
        i_valid = 1'b1; i_opcode = onehot(`LOAD); i_rd_addr = 5'd2;
        tick();
        exp_ready = 1'b0;
        idle_inputs();
        tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_pc", o_pc, 32'h0);
        chk("async_rst_ready", o_ready, 1'b1);
        chk("async_rst_instret", o_instret, 64'h0);
        m_pc = 32'h0; m_instret = 64'h0; exp_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        txn(`ITYPE, 32'h7, 32'h0, 32'h0, 5'd9, 0, 0, 32'h0);
        chk("post_rst_pc", o_pc, 32'h4);
        chk("post_rst_rd", o_rd, 32'h7);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
